// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronised, debounced up/down buttons step the paddle
// once per movement tick, clamped to the active area; also flags pixels inside the paddle.
module paddle_ctrl #(
  parameter int CLKS_PER_MOVE = 500_000,
  parameter int DEBOUNCE_CLKS = 250_000,
  parameter int STEP          = 4,
  parameter int ACTIVE_ROWS   = 480,
  parameter int ACTIVE_COLS   = 640,
  parameter int PADDLE_WIDTH  = 16,
  parameter int PADDLE_HEIGHT = 64,
  parameter int X_POS         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] row,
  input  logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic [$clog2(ACTIVE_ROWS)-1:0] pos,
  output logic                           paddle_present,
  output logic                           moving
);
  localparam int RW   = $clog2(ACTIVE_ROWS);
  localparam int CW   = $clog2(ACTIVE_COLS);
  localparam int PMAX = ACTIVE_ROWS - PADDLE_HEIGHT;
  localparam int TW   = (CLKS_PER_MOVE > 1) ? $clog2(CLKS_PER_MOVE) : 1;
  localparam int DW   = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, UP, DOWN} dir_t;

  // bit 0 = up, bit 1 = down
  logic [1:0]    sync1, sync2, db;
  logic [DW-1:0] db_cnt [2];
  logic [TW-1:0] tick_cnt;
  logic          tick;
  dir_t          state, state_next;
  logic [RW-1:0] pos_next;
  logic [RW:0]   pos_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CLKS - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tick = (tick_cnt == TW'(CLKS_PER_MOVE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (db[0] && !db[1]) begin
      state_next = UP;
    end else if (!db[0] && db[1]) begin
      state_next = DOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The sum is one bit wider so a step past the bottom cannot wrap.
  assign pos_sum = {1'b0, pos} + (RW+1)'(STEP);

  always_comb begin
    pos_next = pos;
    if (tick) begin
      case (state)
        UP:      pos_next = (pos >= RW'(STEP)) ? pos - RW'(STEP) : '0;
        DOWN:    pos_next = (pos_sum <= (RW+1)'(PMAX)) ? pos_sum[RW-1:0] : RW'(PMAX);
        default: pos_next = pos;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= RW'(PMAX / 2);
      moving <= 1'b0;
    end else begin
      pos    <= pos_next;
      moving <= (pos_next != pos);
    end
  end

  assign paddle_present = ({1'b0, row} >= {1'b0, pos}) &&
                          ({1'b0, row} <  {1'b0, pos} + (RW+1)'(PADDLE_HEIGHT)) &&
                          ({1'b0, col} >= (CW+1)'(X_POS)) &&
                          ({1'b0, col} <  (CW+1)'(X_POS + PADDLE_WIDTH));
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: a default-area instance (a) and a tiny-area instance (b, PMAX=4)
// checked every cycle against a sample-window model, plus literal expectations.
`timescale 1ns/100ps
module tb_paddle_ctrl;
  localparam int CPM  = 4;
  localparam int DEB  = 3;
  localparam int STEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, up_a = 1'b0, down_a = 1'b0;
  logic [8:0] row_a = '0, pos_a;
  logic [9:0] col_a = '0;
  logic       pres_a, mov_a;

  logic       rst_b = 1'b1, up_b = 1'b0, down_b = 1'b0;
  logic [6:0] row_b = '0, pos_b;
  logic [9:0] col_b = '0;
  logic       pres_b, mov_b;

  int total = 0;
  int bad   = 0;

  paddle_ctrl #(.CLKS_PER_MOVE(CPM), .DEBOUNCE_CLKS(DEB), .STEP(STEP)) dut_a (
    .clk(clk), .rst(rst_a), .btn_up(up_a), .btn_down(down_a),
    .row(row_a), .col(col_a), .pos(pos_a), .paddle_present(pres_a), .moving(mov_a));

  paddle_ctrl #(.CLKS_PER_MOVE(CPM), .DEBOUNCE_CLKS(DEB), .STEP(STEP), .ACTIVE_ROWS(68)) dut_b (
    .clk(clk), .rst(rst_b), .btn_up(up_b), .btn_down(down_b),
    .row(row_b), .col(col_b), .pos(pos_b), .paddle_present(pres_b), .moving(mov_b));

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Model: the debounced level flips once the last DEB synchronised samples
  // (raw values from 2..DEB+1 edges ago) all disagree with it.
  bit m_armed [2];
  int m_pos   [2];
  bit m_mov   [2];
  int m_dir   [2];   // 0 idle, 1 up, 2 down
  bit m_dbu   [2];
  bit m_dbd   [2];
  int m_phase [2];
  bit hu      [2][8];
  bit hd      [2][8];

  function automatic int pmax(input int i);
    return (i == 0) ? 416 : 4;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rs, ru, rd, tk, flip_u, flip_d;
      int np;
      rs = (i == 0) ? rst_a  : rst_b;
      ru = (i == 0) ? up_a   : up_b;
      rd = (i == 0) ? down_a : down_b;
      if (rs) begin
        for (int j = 0; j < 8; j++) begin
          hu[i][j] = 1'b0;
          hd[i][j] = 1'b0;
        end
        m_armed[i] = 1'b1;
        m_pos[i]   = pmax(i) / 2;
        m_mov[i]   = 1'b0;
        m_dir[i]   = 0;
        m_dbu[i]   = 1'b0;
        m_dbd[i]   = 1'b0;
        m_phase[i] = 0;
      end else begin
        tk = (m_phase[i] == CPM - 1);
        m_phase[i] = (m_phase[i] + 1) % CPM;
        np = m_pos[i];
        if (tk && m_dir[i] == 1) np = (np - STEP < 0) ? 0 : np - STEP;
        if (tk && m_dir[i] == 2) np = (np + STEP > pmax(i)) ? pmax(i) : np + STEP;
        m_mov[i] = (np != m_pos[i]);
        m_pos[i] = np;
        m_dir[i] = (m_dbu[i] && !m_dbd[i]) ? 1 : (!m_dbu[i] && m_dbd[i]) ? 2 : 0;
        for (int j = 7; j > 0; j--) begin
          hu[i][j] = hu[i][j-1];
          hd[i][j] = hd[i][j-1];
        end
        hu[i][0] = ru;
        hd[i][0] = rd;
        flip_u = 1'b1;
        flip_d = 1'b1;
        for (int j = 2; j < 2 + DEB; j++) begin
          if (hu[i][j] == m_dbu[i]) flip_u = 1'b0;
          if (hd[i][j] == m_dbd[i]) flip_d = 1'b0;
        end
        if (flip_u) m_dbu[i] = ~m_dbu[i];
        if (flip_d) m_dbd[i] = ~m_dbd[i];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_armed[i]) begin
        int r, c, dp, dm, dpr, epr;
        r   = (i == 0) ? int'(row_a)  : int'(row_b);
        c   = (i == 0) ? int'(col_a)  : int'(col_b);
        dp  = (i == 0) ? int'(pos_a)  : int'(pos_b);
        dm  = (i == 0) ? int'(mov_a)  : int'(mov_b);
        dpr = (i == 0) ? int'(pres_a) : int'(pres_b);
        epr = (r >= m_pos[i] && r < m_pos[i] + 64 && c >= 8 && c < 24) ? 1 : 0;
        check((i == 0) ? "model_pos_a" : "model_pos_b", dp, m_pos[i]);
        check((i == 0) ? "model_moving_a" : "model_moving_b", dm, int'(m_mov[i]));
        check((i == 0) ? "model_present_a" : "model_present_b", dpr, epr);
      end
    end
  end

  task automatic reset_a(input bit u, input bit d);
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0; up_a = u; down_a = d;
  endtask

  task automatic reset_b(input bit u, input bit d);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0; up_b = u; down_b = d;
  endtask

  // Edges after reset release until the first move must be 8:
  // 5 to debounce, 1 to register direction, then the tick at phase 3.
  task automatic first_move_a(input string name);
    int k;
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #2;
      if (pos_a != 9'd208) begin
        k = n;
        break;
      end
    end
    check({name, "_latency"}, k, 8);
    check({name, "_pos"}, int'(pos_a), 204);
    check({name, "_moving"}, int'(mov_a), 1);
    @(posedge clk); #2;
    check({name, "_moving_drop"}, int'(mov_a), 0);
  endtask

  task automatic present_at(input int r, input int c, input int want);
    row_a = 9'(r);
    col_a = 10'(c);
    #0.5;
    check($sformatf("present_%0d_%0d", r, c), int'(pres_a), want);
  endtask

  initial begin
    reset_a(1'b0, 1'b0);
    check("reset_pos_a", int'(pos_a), 208);
    check("reset_moving_a", int'(mov_a), 0);

    up_a = 1'b1;
    @(negedge clk); @(negedge clk);
    up_a = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_pos", int'(pos_a), 208);

    reset_a(1'b1, 1'b0);
    first_move_a("debounce");

    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 300; n++) begin
        @(posedge clk); #2;
        if (pos_a == 9'd100) begin
          hit = 1'b1;
          break;
        end
      end
      check("reach_100", int'(pos_a), 100);
      if (hit) begin
        present_at(100, 8, 1);
        present_at(163, 23, 1);
        present_at(99, 8, 0);
        present_at(164, 8, 0);
        present_at(100, 7, 0);
        present_at(100, 24, 0);
      end
    end

    reset_a(1'b1, 1'b0);
    check("midmove_reset_pos", int'(pos_a), 208);
    check("midmove_reset_moving", int'(mov_a), 0);
    first_move_a("rehold");

    reset_a(1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("both_hold_pos", int'(pos_a), 208);

    reset_a(1'b0, 1'b1);
    repeat (300) @(negedge clk);
    check("bottom_clamp_pos", int'(pos_a), 416);
    check("bottom_clamp_moving", int'(mov_a), 0);
    down_a = 1'b0;

    reset_b(1'b0, 1'b1);
    check("reset_pos_b", int'(pos_b), 2);
    repeat (30) @(negedge clk);
    check("partial_bottom_pos_b", int'(pos_b), 4);
    check("partial_bottom_moving_b", int'(mov_b), 0);

    reset_b(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("top_clamp_pos_b", int'(pos_b), 0);
    check("top_clamp_moving_b", int'(mov_b), 0);
    up_b = 1'b0;

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
